// File: rtl/ws2812_pkg.sv
// Shared types, default 50 MHz bit timing and the brightness scaler for the WS2812 strip driver.
package ws2812_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FIRST,
    HIGH,
    LOW,
    LATCH
  } state_e;

  localparam int T0H_50M = 20;
  localparam int T0L_50M = 43;
  localparam int T1H_50M = 40;
  localparam int T1L_50M = 22;
  localparam int RES_50M = 3000;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // (ch * (brightness + 1)) >> 8: 255 is identity, 0 blanks the channel.
  function automatic logic [7:0] scale8(input logic [7:0] ch, input logic [7:0] brightness);
    logic [15:0] prod;
    prod = 16'(ch) * (16'(brightness) + 16'd1);
    return prod[15:8];
  endfunction

endpackage

// File: rtl/ws2812_pixel_buffer.sv
// One-entry pixel holding register; channels are brightness-scaled as they are written.
import ws2812_pkg::*;

module ws2812_pixel_buffer #(
  parameter int BITS_PER_LED = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [BITS_PER_LED-1:0] pix_data,
  input  logic [7:0]              brightness,
  output logic                    full,
  output logic [BITS_PER_LED-1:0] data
);

  localparam int NCH = BITS_PER_LED / 8;

  logic                    full_d, full_q;
  logic [BITS_PER_LED-1:0] data_d, data_q;

  always_comb begin
    full_d = full_q;
    if (flush)     full_d = 1'b0;
    else if (push) full_d = 1'b1;
    else if (pop)  full_d = 1'b0;

    data_d = data_q;
    if (push) begin
      for (int c = 0; c < NCH; c++) begin
        data_d[c*8 +: 8] = scale8(pix_data[c*8 +: 8], brightness);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) full_q <= 1'b0;
    else        full_q <= full_d;
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign full = full_q;
  assign data = data_q;

endmodule

// File: rtl/ws2812_strip_driver.sv
// WS2812/SK6812 chain driver: pulls NUM_LEDS pixels per frame, serialises them MSB first
// with back-to-back bit periods, then holds the line low for the latch gap.
import ws2812_pkg::*;

module ws2812_strip_driver #(
  parameter int NUM_LEDS     = 8,
  parameter int BITS_PER_LED = 24,
  parameter int T0H          = T0H_50M,
  parameter int T0L          = T0L_50M,
  parameter int T1H          = T1H_50M,
  parameter int T1L          = T1L_50M,
  parameter int RES          = RES_50M
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [7:0]              brightness,
  input  logic [BITS_PER_LED-1:0] pix_data,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  output logic                    data_out,
  output logic                    busy,
  output logic                    done,
  output logic                    underrun
);

  localparam int MAX_T = max2(max2(max2(T0H, T0L), max2(T1H, T1L)), RES);
  localparam int CNT_W = $clog2(MAX_T + 1);
  localparam int BIT_W = $clog2(BITS_PER_LED);
  localparam int LED_W = $clog2(NUM_LEDS + 1);

  localparam logic [CNT_W-1:0] T0H_C = CNT_W'(T0H - 1);
  localparam logic [CNT_W-1:0] T0L_C = CNT_W'(T0L - 1);
  localparam logic [CNT_W-1:0] T1H_C = CNT_W'(T1H - 1);
  localparam logic [CNT_W-1:0] T1L_C = CNT_W'(T1L - 1);
  localparam logic [CNT_W-1:0] RES_C = CNT_W'(RES - 1);

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [BIT_W-1:0]        bit_q;
  logic [LED_W-1:0]        left_q, accepted_q;
  logic [BITS_PER_LED-1:0] shift_q;
  logic                    data_out_q, busy_q, done_q, underrun_q;

  logic                    buf_full, push, flush, end_low, last_bit, load_sh, shift_sh, next_bit;
  logic [BITS_PER_LED-1:0] buf_data;
  logic [CNT_W-1:0]        high_len, low_len;

  assign pix_ready = busy_q && !buf_full && (accepted_q < LED_W'(NUM_LEDS)) && (state_q != LATCH);
  assign push      = pix_valid && pix_ready;
  assign flush     = (state_q == IDLE) && start;
  assign end_low   = (state_q == LOW) && (cnt_q == '0);
  assign last_bit  = (bit_q == '0);
  assign load_sh   = buf_full && ((state_q == WAIT_FIRST) || (end_low && last_bit && (left_q != '0)));
  assign shift_sh  = end_low && !last_bit;
  // HIGH length is chosen by the bit about to go out, which is not yet in shift_q[MSB].
  assign next_bit  = load_sh ? buf_data[BITS_PER_LED-1] : shift_q[BITS_PER_LED-2];
  assign high_len  = next_bit ? T1H_C : T0H_C;
  assign low_len   = shift_q[BITS_PER_LED-1] ? T1L_C : T0L_C;

  ws2812_pixel_buffer #(.BITS_PER_LED(BITS_PER_LED)) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .pop        (load_sh),
    .flush      (flush),
    .pix_data   (pix_data),
    .brightness (brightness),
    .full       (buf_full),
    .data       (buf_data)
  );

  always_ff @(posedge clk) begin
    if (load_sh)       shift_q <= buf_data;
    else if (shift_sh) shift_q <= {shift_q[BITS_PER_LED-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      left_q     <= '0;
      accepted_q <= '0;
      data_out_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      if (push) accepted_q <= accepted_q + LED_W'(1);
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= WAIT_FIRST;
            busy_q     <= 1'b1;
            left_q     <= LED_W'(NUM_LEDS);
            accepted_q <= '0;
          end
        end
        WAIT_FIRST: begin
          if (load_sh) begin
            state_q    <= HIGH;
            data_out_q <= 1'b1;
            cnt_q      <= high_len;
            bit_q      <= BIT_W'(BITS_PER_LED - 1);
            left_q     <= left_q - LED_W'(1);
          end
        end
        HIGH: begin
          if (cnt_q == '0) begin
            state_q    <= LOW;
            data_out_q <= 1'b0;
            cnt_q      <= low_len;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        LOW: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (!last_bit) begin
            state_q    <= HIGH;
            data_out_q <= 1'b1;
            cnt_q      <= high_len;
            bit_q      <= bit_q - BIT_W'(1);
          end else if (load_sh) begin
            state_q    <= HIGH;
            data_out_q <= 1'b1;
            cnt_q      <= high_len;
            bit_q      <= BIT_W'(BITS_PER_LED - 1);
            left_q     <= left_q - LED_W'(1);
          end else begin
            // Out of pixels, either by design or because the source fell behind.
            underrun_q <= (left_q != '0);
            state_q    <= LATCH;
            cnt_q      <= RES_C;
          end
        end
        LATCH: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out = data_out_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_ws2812_strip_driver.sv
// Bench for ws2812_strip_driver: three configurations, line decoded into high/low runs and compared to a frame model.
module tb_ws2812_strip_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i [3];
  logic [7:0]  br [3];
  logic [31:0] pd [3];
  logic        pv [3];
  logic        pr [3];
  logic        dout [3];
  logic        bsy [3];
  logic        dn [3];
  logic        ur [3];

  int checks = 0;
  int errors = 0;
  logic [31:0] sq[$];
  logic [31:0] eq[$];

  typedef struct {
    logic [31:0] pix;
    logic [7:0]  b;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [6];

  always #5 clk = ~clk;

  ws2812_strip_driver #(.NUM_LEDS(1), .BITS_PER_LED(24)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_i[0]), .brightness(br[0]), .pix_data(pd[0][23:0]),
    .pix_valid(pv[0]), .pix_ready(pr[0]), .data_out(dout[0]), .busy(bsy[0]), .done(dn[0]), .underrun(ur[0]));

  ws2812_strip_driver #(.NUM_LEDS(3), .BITS_PER_LED(24), .T0H(3), .T0L(5), .T1H(6), .T1L(2), .RES(30)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_i[1]), .brightness(br[1]), .pix_data(pd[1][23:0]),
    .pix_valid(pv[1]), .pix_ready(pr[1]), .data_out(dout[1]), .busy(bsy[1]), .done(dn[1]), .underrun(ur[1]));

  ws2812_strip_driver #(.NUM_LEDS(2), .BITS_PER_LED(32), .T0H(3), .T0L(5), .T1H(6), .T1L(2), .RES(30)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_i[2]), .brightness(br[2]), .pix_data(pd[2]),
    .pix_valid(pv[2]), .pix_ready(pr[2]), .data_out(dout[2]), .busy(bsy[2]), .done(dn[2]), .underrun(ur[2]));

  function automatic int t0h(input int s); return (s == 0) ? 20 : 3; endfunction
  function automatic int t0l(input int s); return (s == 0) ? 43 : 5; endfunction
  function automatic int t1h(input int s); return (s == 0) ? 40 : 6; endfunction
  function automatic int t1l(input int s); return (s == 0) ? 22 : 2; endfunction
  function automatic int res(input int s); return (s == 0) ? 3000 : 30; endfunction
  function automatic int nleds(input int s); return (s == 0) ? 1 : ((s == 1) ? 3 : 2); endfunction
  function automatic int bw(input int s); return (s == 2) ? 32 : 24; endfunction
  function automatic int maxlow(input int s); return (t0l(s) > t1l(s)) ? t0l(s) : t1l(s); endfunction

  function automatic logic [31:0] model_px(input logic [31:0] p, input int b, input int w);
    int v;
    logic [31:0] r;
    r = '0;
    for (int ch = 0; ch < w / 8; ch++) begin
      v = int'((p >> (8 * ch)) & 32'hFF);
      r = r | (32'((v * (b + 1)) / 256) << (8 * ch));
    end
    return r;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Runs one frame on instance s, feeding sq[0..nsend-1]; eq holds the expected transmitted pixels.
  task automatic run_frame(input int s, input int nsend, input logic [7:0] b, input int exp_und,
                           input int restart_at, input string nm);
    int hi[$];
    int lo[$];
    int cur, lvl, started, idx, und_n, und_idx, last_hi, done_early, pr_bad, bad_t, nb, w, nbits;
    int eb, eh, el, lastl, thr, fin, acc_exp;
    logic [31:0] px;
    bit xfer;
    cur = 0; lvl = 0; started = 0; idx = 0; und_n = 0; und_idx = -1; last_hi = -1;
    done_early = 0; pr_bad = 0; bad_t = 0; fin = 0; xfer = 1'b0;
    w = bw(s);
    br[s] = b;
    start_i[s] = 1'b1;
    @(posedge clk); #1;
    start_i[s] = 1'b0;
    for (int c = 0; c < 20000 && fin == 0; c++) begin
      if (xfer) idx++;
      if (ur[s]) begin und_n++; und_idx = c; end
      if (!bsy[s]) begin
        if (started != 0 && lvl == 0) lo.push_back(cur);
        fin = 1;
      end else begin
        if (dn[s]) done_early++;
        if (dout[s]) begin
          if (started != 0 && lvl == 0) begin lo.push_back(cur); cur = 0; end
          started = 1; lvl = 1; cur++; last_hi = c;
        end else if (started != 0) begin
          if (lvl == 1) begin hi.push_back(cur); cur = 0; end
          lvl = 0; cur++;
          if (cur > maxlow(s) && pr[s]) pr_bad++;
        end
        start_i[s] = (c == restart_at);
        pv[s] = (idx < nsend) && ($urandom_range(0, 3) != 0);
        pd[s] = (idx < nsend) ? sq[idx] : $urandom;
        xfer = pv[s] && pr[s];
        @(posedge clk); #1;
      end
    end
    pv[s] = 1'b0;
    start_i[s] = 1'b0;
    chk({nm, " finished"}, fin, 1);
    chk({nm, " done_pulse"}, dn[s], 1);
    chk({nm, " done_early"}, done_early, 0);

    nbits = eq.size() * w;
    chk({nm, " bit_count"}, hi.size(), nbits);
    chk({nm, " low_count"}, lo.size(), nbits);
    nb = (hi.size() < nbits) ? hi.size() : nbits;
    if (lo.size() < nb) nb = lo.size();
    lastl = 0;
    for (int i = 0; i < nbits; i++) begin
      eb = int'(eq[i / w][w - 1 - (i % w)]);
      eh = (eb != 0) ? t1h(s) : t0h(s);
      el = ((eb != 0) ? t1l(s) : t0l(s));
      if (i == nbits - 1) begin lastl = el; el = el + res(s); end
      if (i < nb && (hi[i] != eh || lo[i] != el)) begin
        if (bad_t == 0) $display("FAIL %s bit%0d: high %0d low %0d, expected %0d/%0d", nm, i, hi[i], lo[i], eh, el);
        bad_t++;
      end
    end
    chk({nm, " bad_bit_timing"}, bad_t, 0);

    thr = (t0h(s) + t1h(s)) / 2;
    for (int k = 0; k < eq.size(); k++) begin
      px = '0;
      for (int j = 0; j < w; j++) begin
        if (k * w + j < hi.size()) px = (px << 1) | ((hi[k * w + j] > thr) ? 32'd1 : 32'd0);
      end
      chk($sformatf("%s pixel%0d", nm, k), px, eq[k]);
    end

    chk({nm, " underrun_count"}, und_n, exp_und);
    if (exp_und != 0) chk({nm, " underrun_cycle"}, und_idx, last_hi + lastl + 1);
    acc_exp = (nsend < nleds(s)) ? nsend : nleds(s);
    chk({nm, " accepted"}, idx, acc_exp);
    chk({nm, " ready_in_latch"}, pr_bad, 0);

    @(posedge clk); #1;
    chk({nm, " done_one_cycle"}, dn[s], 0);
    chk({nm, " idle_low"}, dout[s], 0);
  endtask

  initial begin
    int n, nsend;
    logic [7:0] b;
    logic [31:0] p, mask;

    tbl[0] = '{pix: 32'hFF0000, b: 8'd255, exp: 32'hFF0000};
    tbl[1] = '{pix: 32'h123456, b: 8'd255, exp: 32'h123456};
    tbl[2] = '{pix: 32'hFFFFFF, b: 8'd127, exp: 32'h7F7F7F};
    tbl[3] = '{pix: 32'h804020, b: 8'd127, exp: 32'h402010};
    tbl[4] = '{pix: 32'hFF8001, b: 8'd1,   exp: 32'h010100};
    tbl[5] = '{pix: 32'hA5A5A5, b: 8'd0,   exp: 32'h000000};

    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) begin
      start_i[s] = 1'b0; br[s] = 8'd255; pd[s] = '0; pv[s] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("rst data_out%0d", s), dout[s], 0);
      chk($sformatf("rst busy%0d", s), bsy[s], 0);
      chk($sformatf("rst done%0d", s), dn[s], 0);
      chk($sformatf("rst underrun%0d", s), ur[s], 0);
      chk($sformatf("rst ready%0d", s), pr[s], 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) begin
      sq.delete(); eq.delete();
      sq.push_back(tbl[v].pix);
      eq.push_back(tbl[v].exp);
      run_frame(0, 1, tbl[v].b, 0, -1, $sformatf("tbl%0d", v));
    end

    sq.delete(); eq.delete();
    sq.push_back(32'hFFFFFF); sq.push_back(32'h000000); sq.push_back(32'hFFFFFF);
    eq.push_back(32'h7F7F7F); eq.push_back(32'h000000); eq.push_back(32'h7F7F7F);
    run_frame(1, 3, 8'd127, 0, -1, "half_bright");

    sq.delete(); eq.delete();
    sq.push_back(32'hC3A501);
    eq.push_back(32'hC3A501);
    run_frame(1, 1, 8'd255, 1, -1, "underrun");

    sq.delete(); eq.delete();
    sq.push_back(32'h0F0F0F); sq.push_back(32'hF0F0F0); sq.push_back(32'h5A5A5A);
    eq.push_back(32'h0F0F0F); eq.push_back(32'hF0F0F0); eq.push_back(32'h5A5A5A);
    run_frame(1, 3, 8'd255, 0, 100, "restart_ignored");

    // Reset asserted in the middle of a high pulse.
    br[1] = 8'd255; start_i[1] = 1'b1;
    @(posedge clk); #1;
    start_i[1] = 1'b0; pv[1] = 1'b1; pd[1] = 32'hFFFFFF;
    for (int c = 0; c < 200 && !dout[1]; c++) begin
      @(posedge clk); #1;
    end
    chk("rst_mid reached_high", dout[1], 1);
    pv[1] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid data_out", dout[1], 0);
    chk("rst_mid busy", bsy[1], 0);
    chk("rst_mid ready", pr[1], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    sq.delete(); eq.delete();
    sq.push_back(32'h800001); sq.push_back(32'h00FF00); sq.push_back(32'h3C3C3C);
    eq.push_back(32'h800001); eq.push_back(32'h00FF00); eq.push_back(32'h3C3C3C);
    run_frame(1, 3, 8'd255, 0, -1, "after_reset");

    sq.delete(); eq.delete();
    sq.push_back(32'h000000FF); sq.push_back(32'hFF00FF00);
    eq.push_back(32'h000000FF); eq.push_back(32'hFF00FF00);
    run_frame(2, 2, 8'd255, 0, -1, "grbw_full");

    sq.delete(); eq.delete();
    sq.push_back(32'h000000FF); sq.push_back(32'hFF00FF00);
    eq.push_back(32'h0000007F); eq.push_back(32'h7F007F00);
    run_frame(2, 2, 8'd127, 0, -1, "grbw_half");

    for (int f = 0; f < 6; f++) begin
      for (int s = 1; s < 3; s++) begin
        n = nleds(s);
        nsend = n + int'($urandom_range(0, 1));
        b = 8'($urandom);
        mask = (bw(s) == 32) ? 32'hFFFFFFFF : 32'h00FFFFFF;
        sq.delete(); eq.delete();
        for (int k = 0; k < nsend; k++) begin
          p = $urandom & mask;
          sq.push_back(p);
          if (k < n) eq.push_back(model_px(p, int'(b), bw(s)));
        end
        run_frame(s, nsend, b, 0, -1, $sformatf("rand%0d_%0d", f, s));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
